// File: rtl/fi_output_monitor.sv
// Observer for the fault-injection flop chain: checks o3 == ~o2 and o2 == previous o1 once armed.
// Define FI_MON_TRACE_EN to add a trace FIFO logging every violation with its timestamp.
module fi_output_monitor #(
    parameter int unsigned TS_W   = 16,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned SETTLE = 2
`ifdef FI_MON_TRACE_EN
    ,
    parameter int unsigned TRACE_DEPTH = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             o1,
    input  logic             o2,
    input  logic             o3,
    output logic             fault,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [TS_W-1:0]  first_ts,
    output logic [1:0]       first_type,
    output logic [1:0]       state
`ifdef FI_MON_TRACE_EN
    ,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [TS_W+1:0]  trc_data,
    output logic             trc_overflow
`endif
);

    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MONITOR = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               o1_dly_q, o1_dly_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   fault_cnt_q, fault_cnt_d;
    logic [TS_W-1:0]    first_ts_q, first_ts_d;
    logic [1:0]         first_type_q, first_type_d;

    logic check_en_c;
    logic inv_err_c;
    logic pipe_err_c;
    logic err_c;

    // Violation detection; an arm in the same cycle discards it
    always_comb begin
        check_en_c = (state_q == ST_MONITOR) || (state_q == ST_FAULT);
        inv_err_c  = (o3 == o2);
        pipe_err_c = (o2 != o1_dly_q);
        err_c      = check_en_c && !arm && (inv_err_c || pipe_err_c);
    end

    always_comb begin
        state_d      = state_q;
        set_cnt_d    = set_cnt_q;
        ts_d         = ts_q + TS_W'(1);
        o1_dly_d     = o1;
        fault_d      = fault_q;
        fault_cnt_d  = fault_cnt_q;
        first_ts_d   = first_ts_q;
        first_type_d = first_type_q;

        if (arm) begin
            state_d      = ST_SETTLE;
            set_cnt_d    = '0;
            fault_d      = 1'b0;
            fault_cnt_d  = '0;
            first_ts_d   = '0;
            first_type_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SETTLE: begin
                    if (set_cnt_q == SET_W'(SETTLE - 1)) begin
                        state_d = ST_MONITOR;
                    end else begin
                        set_cnt_d = set_cnt_q + SET_W'(1);
                    end
                end
                ST_MONITOR: begin
                    if (err_c) begin
                        state_d      = ST_FAULT;
                        first_ts_d   = ts_q;
                        first_type_d = {pipe_err_c, inv_err_c};
                    end
                end
                ST_FAULT: ;
                default: state_d = ST_IDLE;
            endcase

            // One count per faulty cycle, saturating
            if (err_c) begin
                fault_d = 1'b1;
                if (fault_cnt_q != '1) begin
                    fault_cnt_d = fault_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            set_cnt_q    <= '0;
            ts_q         <= '0;
            o1_dly_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_cnt_q  <= '0;
            first_ts_q   <= '0;
            first_type_q <= '0;
        end else begin
            state_q      <= state_d;
            set_cnt_q    <= set_cnt_d;
            ts_q         <= ts_d;
            o1_dly_q     <= o1_dly_d;
            fault_q      <= fault_d;
            fault_cnt_q  <= fault_cnt_d;
            first_ts_q   <= first_ts_d;
            first_type_q <= first_type_d;
        end
    end

    assign fault      = fault_q;
    assign fault_cnt  = fault_cnt_q;
    assign first_ts   = first_ts_q;
    assign first_type = first_type_q;
    assign state      = state_q;

`ifdef FI_MON_TRACE_EN
    localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [TS_W+1:0]  mem_q [TRACE_DEPTH];
    logic [TS_W+1:0]  mem_d [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             trc_valid_q, trc_valid_d;
    logic             trc_overflow_q, trc_overflow_d;
    logic             pop_c;
    logic             full_c;
    logic             push_c;

    // Trace FIFO: a pop frees the slot for a push in the same cycle, so full+pop+push never drops
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q;
        trc_overflow_d = trc_overflow_q;
        pop_c          = trc_valid_q && trc_ready;
        full_c         = (occ_q == OCC_W'(TRACE_DEPTH));
        push_c         = err_c && (!full_c || pop_c);

        if (arm) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            occ_d          = '0;
            trc_overflow_d = 1'b0;
        end else begin
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_c) begin
                mem_d[wr_ptr_q] = {pipe_err_c, inv_err_c, ts_q};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (err_c && full_c && !pop_c) begin
                trc_overflow_d = 1'b1;
            end
            case ({push_c, pop_c})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
        trc_valid_d = (occ_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q          <= '{default: '0};
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            occ_q          <= '0;
            trc_valid_q    <= 1'b0;
            trc_overflow_q <= 1'b0;
        end else begin
            mem_q          <= mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            trc_valid_q    <= trc_valid_d;
            trc_overflow_q <= trc_overflow_d;
        end
    end

    assign trc_valid    = trc_valid_q;
    assign trc_data     = mem_q[rd_ptr_q];
    assign trc_overflow = trc_overflow_q;
`endif

endmodule
